// File: rtl/dpram_arb_pkg.sv
// Shared types for the label-RAM arbiter: port count, port selector and request kind.
package dpram_arb_pkg;

    localparam int unsigned MAX_PORTS = 2;

    typedef logic [$clog2(MAX_PORTS)-1:0] port_sel_t;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_t;

endpackage

// File: rtl/dpram_arb_rr_scan.sv
// Rotating scan picker: grants up to two reads and two writes per cycle, starting at ptr_i.
module dpram_arb_rr_scan
    import dpram_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned S  = 20,
    parameter int unsigned PW = $clog2(N)
) (
    input  logic [PW-1:0]       ptr_i,
    input  logic [N-1:0]        valid_i,
    input  logic [N-1:0]        we_i,
    input  logic [N-1:0][S-1:0] addr_i,
    output logic [N-1:0]        grant_o,
    output port_sel_t [N-1:0]   port_o,
    output logic [PW-1:0]       last_o
);

    logic [PW:0]   pos;
    logic [PW-1:0] idx;
    logic [1:0]    n_rd;
    logic [1:0]    n_wr;
    logic [S-1:0]  wr_addr0;

    always_comb begin
        grant_o  = '0;
        port_o   = '0;
        last_o   = '0;
        pos      = '0;
        idx      = '0;
        n_rd     = '0;
        n_wr     = '0;
        wr_addr0 = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // Modular add kept one bit wider so non-power-of-two N wraps correctly.
            pos = {1'b0, ptr_i} + (PW+1)'(k);
            if (pos >= (PW+1)'(N)) begin
                pos = pos - (PW+1)'(N);
            end
            idx = pos[PW-1:0];
            if (valid_i[idx]) begin
                if (we_i[idx] == REQ_READ) begin
                    if (n_rd < 2'd2) begin
                        grant_o[idx] = 1'b1;
                        port_o[idx]  = n_rd[0];
                        n_rd         = n_rd + 2'd1;
                        last_o       = idx;
                    end
                end else if (n_wr == 2'd0 || (n_wr == 2'd1 && addr_i[idx] != wr_addr0)) begin
                    grant_o[idx] = 1'b1;
                    port_o[idx]  = n_wr[0];
                    if (n_wr == 2'd0) begin
                        wr_addr0 = addr_i[idx];
                    end
                    n_wr   = n_wr + 2'd1;
                    last_o = idx;
                end
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Shares a 2R/2W label RAM among N requesters with round-robin grants and 1-cycle read return.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned S  = 20,
    parameter int unsigned K  = 128,
    parameter int unsigned CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req_valid,
    input  logic [N-1:0]        req_we,
    input  logic [N-1:0][S-1:0] req_addr,
    input  logic [N-1:0][K-1:0] req_wdata,
    output logic [N-1:0]        req_ready,
    output logic [N-1:0]        rsp_valid,
    output logic [N-1:0][K-1:0] rsp_data,
    output logic                ram_wr_en_0,
    output logic                ram_wr_en_1,
    output logic [S-1:0]        ram_wr_addr_0,
    output logic [S-1:0]        ram_wr_addr_1,
    output logic [K-1:0]        ram_wr_data_0,
    output logic [K-1:0]        ram_wr_data_1,
    output logic [S-1:0]        ram_rd_addr_0,
    output logic [S-1:0]        ram_rd_addr_1,
    input  logic [K-1:0]        ram_rd_data_0,
    input  logic [K-1:0]        ram_rd_data_1,
    output logic [CW-1:0]       stall_cnt
);

    localparam int unsigned PW = $clog2(N);

    logic [PW-1:0]        ptr_q, ptr_d;
    logic [N-1:0]         rsp_valid_q, rsp_valid_d;
    logic [N-1:0][K-1:0]  rsp_data_q, rsp_data_d;
    logic [CW-1:0]        stall_q, stall_d;

    logic [N-1:0]         scan_grant;
    logic [N-1:0]         grant;
    port_sel_t [N-1:0]    port_sel;
    logic [PW-1:0]        last_idx;

    dpram_arb_rr_scan #(
        .N  (N),
        .S  (S),
        .PW (PW)
    ) u_scan (
        .ptr_i   (ptr_q),
        .valid_i (req_valid),
        .we_i    (req_we),
        .addr_i  (req_addr),
        .grant_o (scan_grant),
        .port_o  (port_sel),
        .last_o  (last_idx)
    );

    // Nothing is granted or issued to the RAM while reset is held.
    assign grant     = scan_grant & {N{rst}};
    assign req_ready = grant;

    always_comb begin
        ram_wr_en_0   = 1'b0;
        ram_wr_en_1   = 1'b0;
        ram_wr_addr_0 = '0;
        ram_wr_addr_1 = '0;
        ram_wr_data_0 = '0;
        ram_wr_data_1 = '0;
        ram_rd_addr_0 = '0;
        ram_rd_addr_1 = '0;
        rsp_valid_d   = '0;
        rsp_data_d    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                if (req_we[i] == REQ_WRITE) begin
                    if (port_sel[i] == '0) begin
                        ram_wr_en_0   = 1'b1;
                        ram_wr_addr_0 = req_addr[i];
                        ram_wr_data_0 = req_wdata[i];
                    end else begin
                        ram_wr_en_1   = 1'b1;
                        ram_wr_addr_1 = req_addr[i];
                        ram_wr_data_1 = req_wdata[i];
                    end
                end else begin
                    rsp_valid_d[i] = 1'b1;
                    if (port_sel[i] == '0) begin
                        ram_rd_addr_0 = req_addr[i];
                        rsp_data_d[i] = ram_rd_data_0;
                    end else begin
                        ram_rd_addr_1 = req_addr[i];
                        rsp_data_d[i] = ram_rd_data_1;
                    end
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (|grant) begin
            ptr_d = (last_idx == PW'(N - 1)) ? '0 : last_idx + PW'(1);
        end
        stall_d = stall_q;
        if (|(req_valid & ~grant) && stall_q != '1) begin
            stall_d = stall_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            stall_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            stall_q     <= stall_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign stall_cnt = stall_q;

endmodule
